// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR/CRC engine: the legal values
// for the configuration strings and a width-generic bit-reverse function.
package lfsr_pkg;

  // Legal values for LFSR_CONFIG.
  localparam string CFG_FIBONACCI = "FIBONACCI";
  localparam string CFG_GALOIS    = "GALOIS";

  // Legal values for STYLE. All three give the same function.
  localparam string STYLE_AUTO      = "AUTO";
  localparam string STYLE_LOOP      = "LOOP";
  localparam string STYLE_REDUCTION = "REDUCTION";

  // Limits on the width parameters.
  localparam int MIN_LFSR_W = 2;
  localparam int MAX_LFSR_W = 128;
  localparam int MIN_DATA_W = 1;
  localparam int MAX_DATA_W = 256;

  // Widest vector bitrev() has to handle: the wider of state and data.
  localparam int MAX_VEC_W = 256;

  // Reverse the low n bits of v. Bits at n and above come back as zero.
  // Used at elaboration time, so the loop never turns into hardware.
  function automatic logic [MAX_VEC_W-1:0] bitrev(input logic [MAX_VEC_W-1:0] v,
                                                  input int n);
    logic [MAX_VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_VEC_W; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_comb.sv
// Next-state function F(state, data) of an LFSR/CRC absorbing DATA_WIDTH
// bits per evaluation. Each output bit is the XOR of a fixed subset of the
// input bits. That subset (a mask) is worked out at elaboration time by
// running the bit-serial update symbolically.
module lfsr_comb
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter int                    REVERSE      = 0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    OUTPUT_WIDTH = LFSR_WIDTH,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic [LFSR_WIDTH-1:0]   state,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [OUTPUT_WIDTH-1:0] next
);

  // Mask bit layout: [LFSR_WIDTH-1:0] selects state bits and
  // [MW-1:LFSR_WIDTH] selects data bits.
  localparam int MW        = LFSR_WIDTH + DATA_WIDTH;
  localparam bit IS_GALOIS = (LFSR_CONFIG == CFG_GALOIS);

  typedef logic [OUTPUT_WIDTH-1:0][MW-1:0] mask_t;

  // Reject illegal parameter values during elaboration.
  if (LFSR_WIDTH < MIN_LFSR_W || LFSR_WIDTH > MAX_LFSR_W) begin : g_bad_lfsr_width
    $error("lfsr: LFSR_WIDTH must be in 2..128");
  end
  if (DATA_WIDTH < MIN_DATA_W || DATA_WIDTH > MAX_DATA_W) begin : g_bad_data_width
    $error("lfsr: DATA_WIDTH must be in 1..256");
  end
  if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > LFSR_WIDTH) begin : g_bad_output_width
    $error("lfsr: OUTPUT_WIDTH must be in 1..LFSR_WIDTH");
  end
  if (LFSR_CONFIG != CFG_FIBONACCI && LFSR_CONFIG != CFG_GALOIS) begin : g_bad_config
    $error("lfsr: LFSR_CONFIG must be FIBONACCI or GALOIS");
  end
  if (REVERSE != 0 && REVERSE != 1) begin : g_bad_reverse
    $error("lfsr: REVERSE must be 0 or 1");
  end
  if (STYLE != STYLE_AUTO && STYLE != STYLE_LOOP && STYLE != STYLE_REDUCTION) begin : g_bad_style
    $error("lfsr: STYLE must be AUTO, LOOP or REDUCTION");
  end

  // Symbolic bit-serial run. s[i] is the set of input bits that state bit i
  // depends on. Data is absorbed MSB first and the state shifts left.
  // REVERSE is handled at the end by remapping indices, because
  //   F_rev(a, d) = bitrev(F(bitrev(a), bitrev(d))).
  function automatic mask_t compute_masks();
    logic [LFSR_WIDTH-1:0][MW-1:0] s;
    logic [MW-1:0]                 fb;
    logic [MW-1:0]                 m;
    logic [MAX_VEC_W-1:0]          tmp;
    mask_t                         r;

    for (int i = 0; i < LFSR_WIDTH; i++) begin
      s[i]    = '0;
      s[i][i] = 1'b1;
    end

    for (int t = 0; t < DATA_WIDTH; t++) begin
      fb = s[LFSR_WIDTH-1];
      fb[MW-1-t] = ~fb[MW-1-t];
      if (IS_GALOIS) begin
        for (int i = LFSR_WIDTH-1; i >= 1; i--) begin
          s[i] = LFSR_POLY[i] ? (s[i-1] ^ fb) : s[i-1];
        end
        s[0] = LFSR_POLY[0] ? fb : '0;
      end else begin
        for (int i = 1; i < LFSR_WIDTH; i++) begin
          if (LFSR_POLY[i]) fb = fb ^ s[i-1];
        end
        for (int i = LFSR_WIDTH-1; i >= 1; i--) begin
          s[i] = s[i-1];
        end
        s[0] = fb;
      end
    end

    for (int j = 0; j < OUTPUT_WIDTH; j++) begin
      if (REVERSE != 0) begin
        m   = s[LFSR_WIDTH-1-j];
        tmp = '0;
        tmp[LFSR_WIDTH-1:0] = m[LFSR_WIDTH-1:0];
        tmp = bitrev(tmp, LFSR_WIDTH);
        r[j][LFSR_WIDTH-1:0] = tmp[LFSR_WIDTH-1:0];
        tmp = '0;
        tmp[DATA_WIDTH-1:0] = m[MW-1:LFSR_WIDTH];
        tmp = bitrev(tmp, DATA_WIDTH);
        r[j][MW-1:LFSR_WIDTH] = tmp[DATA_WIDTH-1:0];
      end else begin
        r[j] = s[j];
      end
    end
    return r;
  endfunction

  localparam mask_t MASKS = compute_masks();

  logic [MW-1:0] in_vec;
  assign in_vec = {data, state};

  if (STYLE == STYLE_LOOP) begin : g_loop
    // Accumulate each output bit with an explicit loop over its mask.
    always_comb begin
      // NOTE: every combinational output gets a default before the loop,
      // so no path leaves a bit unassigned and no latch is inferred.
      next = '0;
      for (int j = 0; j < OUTPUT_WIDTH; j++) begin
        for (int k = 0; k < MW; k++) begin
          if (MASKS[j][k]) next[j] = next[j] ^ in_vec[k];
        end
      end
    end
  end else begin : g_reduction
    // Each output bit is one AND-mask followed by an XOR reduction.
    for (genvar j = 0; j < OUTPUT_WIDTH; j++) begin : g_bit
      assign next[j] = ^(in_vec & MASKS[j]);
    end
  end

endmodule : lfsr_comb

// File: rtl/lfsr.sv
// Registered LFSR/CRC step. Computes F(lfsr_in, data_in) combinationally
// and registers it, giving a latency of one cycle. The module holds no
// other state: to chain steps, the caller feeds lfsr_out back to lfsr_in.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter int                    REVERSE      = 0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    OUTPUT_WIDTH = LFSR_WIDTH,
  parameter string                 STYLE        = "AUTO"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [LFSR_WIDTH-1:0]   lfsr_in,
  output logic [OUTPUT_WIDTH-1:0] lfsr_out
);

  logic [OUTPUT_WIDTH-1:0] next;

  lfsr_comb #(
    .LFSR_WIDTH  (LFSR_WIDTH),
    .LFSR_POLY   (LFSR_POLY),
    .LFSR_CONFIG (LFSR_CONFIG),
    .REVERSE     (REVERSE),
    .DATA_WIDTH  (DATA_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .STYLE       (STYLE)
  ) u_comb (
    .state(lfsr_in),
    .data (data_in),
    .next (next)
  );

  // Output register. rst is active low and asynchronous: it clears the
  // output at once and drops any result that is still in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignment, so every flop
    // samples its inputs from before the clock edge.
    if (!rst) lfsr_out <= '0;
    else      lfsr_out <= next;
  end

endmodule : lfsr

// File: tb/tb_lfsr.sv
// Directed bench for lfsr. It drives four instances from one sequence:
//   - a CRC-32 instance (Galois, reflected, 8 data bits),
//   - the default PRBS31 Fibonacci configuration built twice, once with
//     STYLE LOOP and once with STYLE REDUCTION,
//   - a small Galois instance with a narrowed output.
module tb_lfsr;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] crc_in, crc_out;
  logic [7:0]  crc_data;
  logic [30:0] fib_in, fib_out_loop, fib_out_red;
  logic [7:0]  fib_data;
  logic [7:0]  gal_in;
  logic [3:0]  gal_data;
  logic [5:0]  gal_out;

  int n_vec = 0;
  int n_err = 0;

  lfsr #(
    .LFSR_WIDTH(32), .LFSR_POLY(32'h04C11DB7), .LFSR_CONFIG("GALOIS"),
    .REVERSE(1), .DATA_WIDTH(8), .OUTPUT_WIDTH(32), .STYLE("AUTO")
  ) u_crc (
    .clk(clk), .rst(rst), .data_in(crc_data), .lfsr_in(crc_in), .lfsr_out(crc_out)
  );

  lfsr #(
    .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
    .REVERSE(0), .DATA_WIDTH(8), .OUTPUT_WIDTH(31), .STYLE("LOOP")
  ) u_fib_loop (
    .clk(clk), .rst(rst), .data_in(fib_data), .lfsr_in(fib_in), .lfsr_out(fib_out_loop)
  );

  lfsr #(
    .LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
    .REVERSE(0), .DATA_WIDTH(8), .OUTPUT_WIDTH(31), .STYLE("REDUCTION")
  ) u_fib_red (
    .clk(clk), .rst(rst), .data_in(fib_data), .lfsr_in(fib_in), .lfsr_out(fib_out_red)
  );

  lfsr #(
    .LFSR_WIDTH(8), .LFSR_POLY(8'h1D), .LFSR_CONFIG("GALOIS"),
    .REVERSE(0), .DATA_WIDTH(4), .OUTPUT_WIDTH(6), .STYLE("AUTO")
  ) u_gal (
    .clk(clk), .rst(rst), .data_in(gal_data), .lfsr_in(gal_in), .lfsr_out(gal_out)
  );

  // One comparison: count it, and on a mismatch count the failure and
  // report it.
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reverse the low n bits of v.
  function automatic logic [255:0] rev_n(input logic [255:0] v, input int n);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

  // Bit-serial reference model of one word step.
  function automatic logic [127:0] model(input logic [127:0] s_in, input logic [255:0] d_in,
                                         input int w, input logic [127:0] poly,
                                         input bit galois, input bit rev, input int dw);
    logic [127:0] s;
    logic [255:0] d;
    logic [255:0] t;
    logic         fb;
    s = s_in;
    d = d_in;
    if (rev) begin
      t = rev_n({128'b0, s}, w);
      s = t[127:0];
      d = rev_n(d, dw);
    end
    for (int k = 0; k < dw; k++) begin
      fb = d[dw-1-k] ^ s[w-1];
      if (galois) begin
        s = s << 1;
        if (fb) s = s ^ poly;
      end else begin
        for (int i = 1; i < w; i++) if (poly[i]) fb = fb ^ s[i-1];
        s = s << 1;
        s[0] = fb;
      end
      for (int i = w; i < 128; i++) s[i] = 1'b0;
    end
    if (rev) begin
      t = rev_n({128'b0, s}, w);
      s = t[127:0];
    end
    return s;
  endfunction

  function automatic logic [127:0] crc_model(input logic [31:0] s, input logic [7:0] d);
    return model(128'(s), 256'(d), 32, 128'h04C11DB7, 1'b1, 1'b1, 8);
  endfunction

  function automatic logic [127:0] fib_model(input logic [30:0] s, input logic [7:0] d);
    return model(128'(s), 256'(d), 31, 128'h10000001, 1'b0, 1'b0, 8);
  endfunction

  function automatic logic [127:0] gal_model(input logic [7:0] s, input logic [3:0] d);
    logic [127:0] f;
    f = model(128'(s), 256'(d), 8, 128'h1D, 1'b1, 1'b0, 4);
    return 128'(f[5:0]);
  endfunction

  // Wait for the active edge, then sample a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]   msg [9];
  logic [7:0]   gv_in   [5];
  logic [3:0]   gv_data [5];
  logic [5:0]   gv_exp  [5];
  logic [30:0]  fib_hand [4];
  logic [127:0] exp_state;
  logic [31:0]  crc_fin;

  initial begin
    msg      = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    // Small Galois instance, worked by hand (poly 0x1D, 4 data bits, 6 output bits).
    gv_in    = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
    gv_data  = '{4'h8,  4'h1,  4'h0,  4'h1,  4'h0};
    gv_exp   = '{6'h28, 6'h1D, 6'h10, 6'h0D, 6'h00};
    // First PRBS31 words from 7FFFFFFF, worked by hand.
    fib_hand = '{31'h7FFFFF00, 31'h7FFF0000, 31'h7F000000, 31'h0000000E};

    // Reset is asserted and the inputs are nonzero.
    rst      = 1'b0;
    crc_in   = 32'hFFFFFFFF; crc_data = 8'h00;
    fib_in   = 31'h7FFFFFFF; fib_data = 8'h00;
    gal_in   = 8'h80;        gal_data = 4'h0;
    #2;
    check("reset_crc",      128'(crc_out),      128'h0);
    check("reset_fib_loop", 128'(fib_out_loop), 128'h0);
    check("reset_fib_red",  128'(fib_out_red),  128'h0);
    check("reset_gal",      128'(gal_out),      128'h0);
    tick();
    check("reset_held_crc", 128'(crc_out), 128'h0);

    // Release reset between edges. The first edge after release loads F.
    @(negedge clk) rst = 1'b1;
    tick();
    check("crc_ff_00",    128'(crc_out),      128'h2DFD1072);
    check("fib_loop_1st", 128'(fib_out_loop), 128'(fib_hand[0]));
    check("fib_red_1st",  128'(fib_out_red),  128'(fib_hand[0]));
    check("gal_80_0",     128'(gal_out),      128'h28);

    // Hand-computed Galois vectors, including the narrowed output.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gal_in = gv_in[i]; gal_data = gv_data[i];
      tick();
      check($sformatf("gal_vec%0d", i), 128'(gal_out), 128'(gv_exp[i]));
    end

    // PRBS31 words 2..4 from the hand table, fed back by the bench.
    for (int i = 1; i < 4; i++) begin
      @(negedge clk) fib_in = fib_out_red;
      tick();
      check($sformatf("fib_hand%0d", i), 128'(fib_out_red), 128'(fib_hand[i]));
    end

    // PRBS31 for 100 cycles from 7FFFFFFF against the serial model.
    // Both codings must track the model, so they also match each other.
    exp_state = 128'h7FFFFFFF;
    @(negedge clk) fib_in = 31'h7FFFFFFF;
    for (int c = 0; c < 100; c++) begin
      tick();
      exp_state = fib_model(exp_state[30:0], 8'h00);
      check($sformatf("prbs_red_c%0d", c),  128'(fib_out_red),  exp_state);
      check($sformatf("prbs_loop_c%0d", c), 128'(fib_out_loop), exp_state);
      @(negedge clk) fib_in = fib_out_red;
    end

    // CRC-32 of "123456789", with the output fed back to the input.
    @(negedge clk) crc_in = 32'hFFFFFFFF;
    exp_state = 128'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      crc_data = msg[i];
      tick();
      exp_state = crc_model(exp_state[31:0], msg[i]);
      check($sformatf("crc_msg_b%0d", i), 128'(crc_out), exp_state);
      @(negedge clk) crc_in = crc_out;
    end
    crc_fin = ~crc_out;
    check("crc_check_value", 128'(crc_fin), 128'hCBF43926);

    // An all-zero state with all-zero data maps to zero.
    @(negedge clk);
    crc_in = '0; crc_data = '0; fib_in = '0; fib_data = '0; gal_in = '0; gal_data = '0;
    tick();
    check("zero_crc", 128'(crc_out),     128'h0);
    check("zero_fib", 128'(fib_out_red), 128'h0);
    check("zero_gal", 128'(gal_out),     128'h0);

    // Random vectors against the serial model.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      crc_in   = $urandom();
      crc_data = 8'($urandom_range(0, 255));
      fib_in   = 31'($urandom());
      fib_data = 8'($urandom_range(0, 255));
      gal_in   = 8'($urandom_range(0, 255));
      gal_data = 4'($urandom_range(0, 15));
      tick();
      check($sformatf("rand_crc%0d", i),  128'(crc_out),      crc_model(crc_in, crc_data));
      check($sformatf("rand_fibl%0d", i), 128'(fib_out_loop), fib_model(fib_in, fib_data));
      check($sformatf("rand_gal%0d", i),  128'(gal_out),      gal_model(gal_in, gal_data));
    end

    // Assert reset between edges: the output clears at once, and the
    // result that was in flight is discarded.
    @(negedge clk);
    crc_in = 32'h12345678; crc_data = 8'hA5;
    #2 rst = 1'b0;
    #1;
    check("midreset_immediate", 128'(crc_out), 128'h0);
    tick();
    check("midreset_held", 128'(crc_out), 128'h0);
    @(negedge clk) rst = 1'b1;
    tick();
    check("midreset_release", 128'(crc_out), crc_model(32'h12345678, 8'hA5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule : tb_lfsr
